// File: rtl/nanosoc_bm_pkg.sv
// nanosoc bus matrix shared definitions.
// AHB encodings and address-phase bundle used by the input stage, decoder and arbiters.
package nanosoc_bm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef struct packed {
        htrans_e     trans;
        logic        write;
        logic [2:0]  size;
        hburst_e     burst;
        logic [3:0]  prot;
        logic        lock;
    } ap_ctrl_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/nanosoc_bm_input_stage.sv
// nanosoc bus matrix per-master input stage.
// Holds a stalled address phase until the output-stage arbiter grants it.
module nanosoc_bm_input_stage
    import nanosoc_bm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  HREADYOUTM,
    input  logic                  HRESPM,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  sel_trans,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM
);

    logic                  pend_tran;
    logic                  data_phase;
    logic [ADDR_WIDTH-1:0] hold_addr;
    ap_ctrl_t              hold_ctrl;
    ap_ctrl_t              live_ctrl;
    ap_ctrl_t              cur_ctrl;

    logic live_valid;
    logic accept;
    logic load;
    logic err_drop;

    assign live_valid = HSELS & HREADYS & trans_active(HTRANSS);
    assign accept     = active_trans & (pend_tran | live_valid);
    assign load       = live_valid & ~active_trans & ~pend_tran;
    // First ERROR cycle: the master will go IDLE, so the held transfer is dropped.
    assign err_drop   = pend_tran & HRESPM & ~HREADYOUTM;

    assign live_ctrl = '{
        trans: htrans_e'(HTRANSS),
        write: HWRITES,
        size:  HSIZES,
        burst: hburst_e'(HBURSTS),
        prot:  HPROTS,
        lock:  HMASTLOCKS
    };

    // Pending flag: set on an ungranted live transfer, cleared by grant or error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran <= 1'b0;
        end else if (pend_tran) begin
            if (active_trans | err_drop)
                pend_tran <= 1'b0;
        end else if (load) begin
            pend_tran <= 1'b1;
        end
    end

    // Holding register: captured once, frozen while the master is stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_addr <= '0;
            hold_ctrl <= '{
                trans: HTRANS_IDLE,
                burst: HBURST_SINGLE,
                default: '0
            };
        end else if (load) begin
            hold_addr <= HADDRS;
            hold_ctrl <= live_ctrl;
        end
    end

    // Outstanding data phase: starts on accept, ends on HREADYOUTM.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            data_phase <= 1'b0;
        else if (accept)
            data_phase <= 1'b1;
        else if (HREADYOUTM)
            data_phase <= 1'b0;
    end

    // Address-phase mux: held transfer wins over the live bus.
    always_comb begin
        HADDRM    = HADDRS;
        cur_ctrl  = live_ctrl;
        sel_trans = live_valid;
        if (pend_tran) begin
            HADDRM    = hold_addr;
            cur_ctrl  = hold_ctrl;
            sel_trans = 1'b1;
        end
    end

    assign HTRANSM    = cur_ctrl.trans;
    assign HWRITEM    = cur_ctrl.write;
    assign HSIZEM     = cur_ctrl.size;
    assign HBURSTM    = cur_ctrl.burst;
    assign HPROTM     = cur_ctrl.prot;
    assign HMASTLOCKM = cur_ctrl.lock;

    // Master-side response: wait while pending, else forward the data phase.
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        if (pend_tran)
            HREADYOUTS = 1'b0;
        else if (data_phase)
            HREADYOUTS = HREADYOUTM;
        if (data_phase)
            HRESPS = HRESPM;
    end

endmodule
